// File: rtl/seq_frame_tx_1011.sv
// seq_frame_tx_1011: serial frame transmitter sending sync 1011, then an MSB-first payload, then a gap of zeros
//   clk, reset       : rising-edge clock, synchronous active-high reset
//   in_data/in_valid : payload word and its valid; in_ready is high only in IDLE
//   abort            : ends the current frame early (SYNC/DATA only); the full gap still follows
//   out_bit/out_valid: registered serial line, with a valid that marks the sync and payload bits
//   busy, frame_done : not-IDLE flag; one-cycle pulse on the first gap cycle of a completed frame
module seq_frame_tx_1011 #(
  parameter int DATA_W   = 8,
  parameter int GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  output logic              out_bit,
  output logic              out_valid,
  output logic              busy,
  output logic              frame_done
);
  localparam int MAXC = (DATA_W > GAP_BITS) ? ((DATA_W > 4) ? DATA_W : 4) : ((GAP_BITS > 4) ? GAP_BITS : 4);
  localparam int CW = $clog2(MAXC);
  typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic out_bit_q, out_bit_d, out_valid_q, out_valid_d, frame_done_q, frame_done_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    shreg_d = shreg_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (in_valid) begin
          state_d = SYNC;
          shreg_d = in_data;
        end
      end
      SYNC: state_d = abort ? GAP : (cnt_q == CW'(3)) ? DATA : SYNC;
      DATA: begin
        shreg_d = shreg_q << 1;
        state_d = abort ? GAP : (cnt_q == CW'(DATA_W - 1)) ? GAP : DATA;
        frame_done_d = !abort && (cnt_q == CW'(DATA_W - 1));
      end
      default: state_d = (cnt_q == CW'(GAP_BITS - 1)) ? IDLE : GAP;
    endcase
    if (state_d != state_q) cnt_d = '0;
    // Outputs are registered from the next state so the first sync bit lands the cycle after the handshake.
    out_valid_d = (state_d == SYNC) || (state_d == DATA);
    out_bit_d = (state_d == SYNC) ? (cnt_d != CW'(1)) : (state_d == DATA) ? shreg_d[DATA_W-1] : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shreg_q <= '0;
      out_bit_q <= 1'b0;
      out_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shreg_q <= shreg_d;
      out_bit_q <= out_bit_d;
      out_valid_q <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign in_ready = (state_q == IDLE);
  assign busy = (state_q != IDLE);
  assign out_bit = out_bit_q;
  assign out_valid = out_valid_q;
  assign frame_done = frame_done_q;
endmodule

// File: doc/seq_frame_tx_1011.md
Name: seq_frame_tx_1011

Overview:
Serial frame transmitter that produces the bit stream consumed by the 1011 sequence detectors.
- Accepts a parallel payload word over a valid/ready handshake.
- Emits a frame on a 1-bit serial line, one bit per clock: sync marker 1011, then the payload MSB-first, then an inter-frame gap of zeros.
- Sits at the transmit end of the serial test link and drives the detector's inp_bit.

Parameters:
DATA_W, 8, payload width in bits; legal range 1..32.
GAP_BITS, 2, zero bits driven after each payload; legal range 1..15.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
in_data  input  DATA_W  payload word; sampled only on handshake.
in_valid  input  1  payload word available.
in_ready  output  1  transmitter can accept a word; high only in IDLE.
abort  input  1  synchronous frame abort; ignored in IDLE.
out_bit  output  1  serial data line, registered.
out_valid  output  1  high while out_bit carries sync or payload bits.
busy  output  1  high in any state other than IDLE.
frame_done  output  1  one-cycle pulse when a frame's last payload bit has been sent.

Behaviour:
- Reset state:
  - state=IDLE; out_bit=0, out_valid=0, busy=0, frame_done=0, in_ready=1.
  - Shift register and bit counter cleared.
- States:
  - IDLE: out_bit=0, out_valid=0. On in_valid&&in_ready at a rising edge, capture in_data into the shift register, clear the counter, go to SYNC.
  - SYNC: 4 cycles driving 1,0,1,1 in that order with out_valid=1. After the 4th bit, go to DATA.
  - DATA: DATA_W cycles driving shreg[DATA_W-1] down to shreg[0] with out_valid=1. After the last bit, go to GAP.
  - GAP: GAP_BITS cycles with out_bit=0 and out_valid=0. Then go to IDLE.
- Timing:
  - Handshake accepted at edge E. The first sync bit appears on out_bit in the cycle after E.
  - Total frame = 4+DATA_W+GAP_BITS cycles, followed by at least one IDLE cycle.
  - Minimum handshake period = 5+DATA_W+GAP_BITS cycles.
- in_ready is combinational from state (state==IDLE) and never depends on in_valid.
- frame_done is registered and high for exactly one cycle: the first GAP cycle. It is not asserted for aborted frames.
- Holding in_valid high in IDLE produces back-to-back frames separated by exactly one IDLE cycle.
- abort:
  - Sampled high in SYNC or DATA: at the next edge go to GAP, counter cleared. out_bit=0 and out_valid=0 from that cycle. The full GAP_BITS zeros are sent, then IDLE.
  - Sampled high in GAP: no effect.
  - abort and reset together: reset wins.
- reset mid-frame: at the next edge, force the IDLE values above. No frame_done; the partial frame is discarded.
- in_data changes while busy have no effect; only the captured copy is shifted.
- Payload bits that themselves contain 1011 are transmitted unmodified; no bit stuffing.
- Counter width is sized to hold max(4, DATA_W, GAP_BITS)-1 and wraps to 0 on every state change.

Test Plan:
- Basic frame (DATA_W=8, GAP_BITS=2): in_data=0xA5 accepted at cycle 0.
  - out_bit cycles 1-14 = 1,0,1,1, 1,0,1,0,0,1,0,1, 0,0.
  - out_valid=1 on cycles 1-12; frame_done=1 only on cycle 13.
  - in_ready=1 again on cycle 15.
- Back-to-back: in_valid held high with 0xFF then 0x00.
  - Second sync starts on cycle 16.
  - Stream is 1011 11111111 00 (idle 0) 1011 00000000 00.
  - Exactly two frame_done pulses.
- Abort in DATA: abort high on cycle 7 (3rd payload bit).
  - Cycles 8-9 out_bit=0 and out_valid=0; IDLE on cycle 10; no frame_done.
- Reset mid-SYNC: reset high on cycle 2.
  - Cycle 3: out_bit=0, busy=0, in_ready=1.
  - A new handshake on cycle 3 produces a full clean frame.
- Loopback: out_bit drives the detector's inp_bit, payload 0x00.
  - Detector seq_seen pulses exactly once per frame, 1 cycle after the 4th sync bit is sampled.
- Parameter sweep: DATA_W=1 with GAP_BITS=1, and DATA_W=32 with GAP_BITS=15.
  - Frame length = 4+DATA_W+GAP_BITS cycles.
  - Payload bit order is MSB-first; frame_done occurs once per frame.
